// File: rtl/led_drv_pkg.sv
// Shared types and defaults for the LED shift-register driver.
package led_drv_pkg;

    // Transmit FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } led_state_t;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_CLK_DIV = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_bit_timer.sv
// Half-period divider for the serial shift clock: tick marks the last cycle
// of each half-period, phase tells which half (0 = ser_clk low, 1 = high).
module led_bit_timer
    import led_drv_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic phase
);

    localparam int DW = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt_reg;
    logic          phase_reg;

    assign tick  = enable && (div_cnt_reg == DIV_LAST);
    assign phase = phase_reg;

    // Count clk cycles within a half-period; flip phase at each wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_cnt_reg <= '0;
            phase_reg   <= 1'b0;
        end else if (enable) begin
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_reg <= '0;
                phase_reg   <= ~phase_reg;
            end else begin
                div_cnt_reg <= div_cnt_reg + DW'(1);
            end
        end
    end

endmodule

// File: rtl/led_shift_driver.sv
// Serialises the LED vector into a 74HC595-style daisy chain (MSB first),
// resending on change, after reset, and optionally on a periodic refresh.
module led_shift_driver
    import led_drv_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] led_in,
    output logic             ser_data,
    output logic             ser_clk,
    output logic             ser_latch,
    output logic             busy,
    output logic             frame_done
);

    localparam int BW = cnt_width(WIDTH);
    localparam int RW = cnt_width(REFRESH_CYCLES);
    localparam logic [BW-1:0] BIT_LAST     = BW'(WIDTH - 1);
    localparam logic [RW-1:0] REFRESH_LAST = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam bit            REFRESH_EN   = (REFRESH_CYCLES > 0);

    led_state_t       state_reg, state_next;
    logic [WIDTH-1:0] shift_data_reg, shift_data_next;
    logic [WIDTH-1:0] shadow_reg, shadow_next;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [RW-1:0]    refresh_cnt_reg, refresh_cnt_next;
    logic             pending_reg, pending_next;
    logic             ser_data_reg, ser_data_next;
    logic             ser_clk_reg, ser_clk_next;
    logic             ser_latch_reg, ser_latch_next;
    logic             busy_reg, busy_next;
    logic             frame_done_reg, frame_done_next;

    logic             frame_start;
    logic             refresh_hit;
    logic             timer_en;
    logic             bit_tick;
    logic             bit_phase;
    logic [WIDTH-1:0] shifted;

    assign timer_en    = (state_reg != IDLE);
    assign refresh_hit = REFRESH_EN && (refresh_cnt_reg == REFRESH_LAST);
    assign shifted     = shift_data_reg << 1;

    led_bit_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (frame_start),
        .enable (timer_en),
        .tick   (bit_tick),
        .phase  (bit_phase)
    );

    // State register plus all registered outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            shift_data_reg  <= '0;
            shadow_reg      <= '0;
            bit_cnt_reg     <= '0;
            refresh_cnt_reg <= '0;
            pending_reg     <= 1'b1;
            ser_data_reg    <= 1'b0;
            ser_clk_reg     <= 1'b0;
            ser_latch_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_data_reg  <= shift_data_next;
            shadow_reg      <= shadow_next;
            bit_cnt_reg     <= bit_cnt_next;
            refresh_cnt_reg <= refresh_cnt_next;
            pending_reg     <= pending_next;
            ser_data_reg    <= ser_data_next;
            ser_clk_reg     <= ser_clk_next;
            ser_latch_reg   <= ser_latch_next;
            busy_reg        <= busy_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    // Next-state and output decode for the transmit FSM.
    always_comb begin
        state_next       = state_reg;
        shift_data_next  = shift_data_reg;
        shadow_next      = shadow_reg;
        bit_cnt_next     = bit_cnt_reg;
        refresh_cnt_next = refresh_cnt_reg;
        pending_next     = pending_reg;
        ser_data_next    = ser_data_reg;
        ser_clk_next     = ser_clk_reg;
        ser_latch_next   = ser_latch_reg;
        busy_next        = busy_reg;
        frame_done_next  = 1'b0;
        frame_start      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // Any combination of triggers yields a single frame.
                if (pending_reg || (led_in != shadow_reg) || refresh_hit) begin
                    frame_start      = 1'b1;
                    shift_data_next  = led_in;
                    shadow_next      = led_in;
                    pending_next     = 1'b0;
                    state_next       = SHIFT;
                    busy_next        = 1'b1;
                    ser_data_next    = led_in[WIDTH-1];
                    ser_clk_next     = 1'b0;
                    bit_cnt_next     = BIT_LAST;
                    refresh_cnt_next = '0;
                end else if (REFRESH_EN) begin
                    refresh_cnt_next = refresh_cnt_reg + RW'(1);
                end
            end

            SHIFT: begin
                if (bit_tick) begin
                    if (!bit_phase) begin
                        ser_clk_next = 1'b1;
                    end else if (bit_cnt_reg == '0) begin
                        // Last bit's high phase done: park the lines and latch.
                        ser_clk_next   = 1'b0;
                        ser_data_next  = 1'b0;
                        ser_latch_next = 1'b1;
                        state_next     = LATCH;
                    end else begin
                        // Data moves only on the falling shift-clock edge.
                        ser_clk_next    = 1'b0;
                        shift_data_next = shifted;
                        ser_data_next   = shifted[WIDTH-1];
                        bit_cnt_next    = bit_cnt_reg - BW'(1);
                    end
                end
            end

            LATCH: begin
                if (bit_tick) begin
                    ser_latch_next   = 1'b0;
                    busy_next        = 1'b0;
                    frame_done_next  = 1'b1;
                    refresh_cnt_next = '0;
                    state_next       = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ser_data   = ser_data_reg;
    assign ser_clk    = ser_clk_reg;
    assign ser_latch  = ser_latch_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: default instance (no refresh) and a
// second instance with a 100-cycle refresh period driven by a constant vector.
module tb_led_shift_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] led_in = 16'h0000;
    logic [15:0] led2 = 16'h5A5A;

    logic ser_data, ser_clk, ser_latch, busy, frame_done;
    logic ser_data2, ser_clk2, ser_latch2, busy2, frame_done2;

    int n_cmp = 0;
    int n_fail = 0;

    // Per-frame capture results.
    logic [15:0] f_bits;
    int f_wait, f_busy, f_latch, f_rises, f_hichg, f_early;
    logic f_fd;
    int chg1_at = -1;
    int chg2_at = -1;
    logic [15:0] chg1_val = 16'h0000;
    logic [15:0] chg2_val = 16'h0000;

    always #5 clk = ~clk;

    led_shift_driver #(
        .WIDTH(16), .CLK_DIV(2), .REFRESH_CYCLES(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led_in),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .ser_latch  (ser_latch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    led_shift_driver #(
        .WIDTH(16), .CLK_DIV(2), .REFRESH_CYCLES(100)
    ) dut_ref (
        .clk        (clk),
        .reset      (reset),
        .led_in     (led2),
        .ser_data   (ser_data2),
        .ser_clk    (ser_clk2),
        .ser_latch  (ser_latch2),
        .busy       (busy2),
        .frame_done (frame_done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for busy, then follow the frame cycle by cycle until busy
    // drops; ends on the sample where frame_done should be high.
    task automatic run_frame();
        logic prev_clk, prev_data;
        f_wait = 0;
        while (!busy && f_wait < 200) begin
            step();
            f_wait++;
        end
        if (!busy) f_wait = -1;
        f_bits = '0; f_busy = 0; f_latch = 0; f_rises = 0; f_hichg = 0; f_early = 0;
        prev_clk = 1'b0;
        prev_data = ser_data;
        while (busy && f_busy < 1000) begin
            f_busy++;
            if (ser_clk && !prev_clk) begin
                f_bits = {f_bits[14:0], ser_data};
                f_rises++;
            end
            if (ser_clk && prev_clk && (ser_data !== prev_data)) f_hichg++;
            if (ser_latch) begin
                f_latch++;
                if (f_rises < 16) f_early++;
            end
            prev_clk = ser_clk;
            prev_data = ser_data;
            if (f_busy == chg1_at) led_in = chg1_val;
            if (f_busy == chg2_at) led_in = chg2_val;
            step();
        end
        f_fd = frame_done;
        $display("frame: bits=%04h busy=%0d latch=%0d rises=%0d wait=%0d done=%0b",
                 f_bits, f_busy, f_latch, f_rises, f_wait, f_fd);
    endtask

    initial begin
        int n;
        int lat;

        // Reset state.
        reset = 1'b1;
        led_in = 16'h0000;
        repeat (3) step();
        check("reset_outputs", {27'd0, ser_data, ser_clk, ser_latch, busy, frame_done}, 32'd0);

        // Frame after reset release.
        reset = 1'b0;
        step();
        check("first_edge_busy", busy, 1);
        run_frame();
        check("f0_bits", f_bits, 16'h0000);
        check("f0_busy_len", f_busy, 66);
        check("f0_latch_len", f_latch, 2);
        check("f0_rises", f_rises, 16);
        check("f0_done", f_fd, 1);
        step();
        check("f0_done_single", frame_done, 0);
        n = 0;
        repeat (10) begin
            if (busy) n++;
            step();
        end
        check("f0_no_resend", n, 0);

        // Pattern A5C3.
        led_in = 16'hA5C3;
        run_frame();
        check("a5_wait", f_wait, 1);
        check("a5_bits", f_bits, 16'hA5C3);
        check("a5_hi_stable", f_hichg, 0);
        check("a5_early_latch", f_early, 0);
        check("a5_latch_len", f_latch, 2);
        check("a5_busy_len", f_busy, 66);
        step();

        // Change mid-frame: current frame intact, follow-up frame right after.
        led_in = 16'h0001;
        chg1_at = 20; chg1_val = 16'h0003;
        run_frame();
        chg1_at = -1;
        check("mid_bits1", f_bits, 16'h0001);
        check("mid_done", f_fd, 1);
        step();
        check("mid_next_busy", busy, 1);
        run_frame();
        check("mid_wait", f_wait, 0);
        check("mid_bits2", f_bits, 16'h0003);
        step();
        check("mid_idle", busy, 0);

        // Change that reverts within the frame: no resend.
        led_in = 16'h00FF;
        chg1_at = 10; chg1_val = 16'h0F00;
        chg2_at = 30; chg2_val = 16'h00FF;
        run_frame();
        chg1_at = -1; chg2_at = -1;
        check("rev_bits", f_bits, 16'h00FF);
        n = 0;
        repeat (200) begin
            if (busy) n++;
            step();
        end
        check("rev_no_resend", n, 0);

        // Reset during bit 7 aborts without latching.
        led_in = 16'h1234;
        step();
        check("abort_busy", busy, 1);
        lat = 0;
        repeat (33) begin
            if (ser_latch) lat++;
            step();
        end
        reset = 1'b1;
        step();
        check("abort_outputs", {27'd0, ser_data, ser_clk, ser_latch, busy, frame_done}, 32'd0);
        check("abort_no_latch", lat, 0);
        led_in = 16'hBEEF;
        step();
        reset = 1'b0;
        step();
        check("abort_restart", busy, 1);
        run_frame();
        check("abort_bits", f_bits, 16'hBEEF);
        check("abort_latch_len", f_latch, 2);
        check("abort_done", f_fd, 1);

        // Periodic refresh on the second instance.
        n = 0;
        while (!frame_done2 && n < 500) begin
            step();
            n++;
        end
        check("ref_done_seen", frame_done2, 1);
        n = 0;
        while (!busy2 && n < 300) begin
            n++;
            step();
        end
        check("ref_gap1", n, 100);
        n = 0;
        while (busy2 && n < 300) begin
            n++;
            step();
        end
        check("ref_busy_len", n, 66);
        check("ref_done2", frame_done2, 1);
        n = 0;
        while (!busy2 && n < 300) begin
            n++;
            step();
        end
        check("ref_gap2", n, 100);
        $display("refresh: gap measured on second frame = %0d", n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
